alp_input_conditioner: RTL

- Front-end stage that feeds the ALP top-level inputs i_OP, i_DATA_IN, i_COMP, i_LOAD and i_CLR from raw board switches and pushbuttons.
- Synchronises every raw input and debounces the three buttons.
- Converts each accepted button press into a single-cycle command pulse.
- Snapshots the operation and data switches on that same edge, so each pulse arrives with stable, aligned operands.

---
 rtl/alp_input_conditioner_if.sv | 24 ++
 rtl/alp_input_conditioner.sv | 117 +++++++++++
 2 files changed

// File: rtl/alp_input_conditioner_if.sv
// Raw switch/button inputs and conditioned ALP command outputs.
// The DUT consumes the slave view; a board-level driver would use master.
interface alp_input_conditioner_if;
    logic       i_btn_comp;
    logic       i_btn_load;
    logic       i_btn_clr;
    logic [2:0] i_sw_op;
    logic [3:0] i_sw_data;
    logic [2:0] o_OP;
    logic [3:0] o_DATA;
    logic       o_COMP;
    logic       o_LOAD;
    logic       o_CLR;

    modport master (
        output i_btn_comp, i_btn_load, i_btn_clr, i_sw_op, i_sw_data,
        input  o_OP, o_DATA, o_COMP, o_LOAD, o_CLR
    );

    modport slave (
        input  i_btn_comp, i_btn_load, i_btn_clr, i_sw_op, i_sw_data,
        output o_OP, o_DATA, o_COMP, o_LOAD, o_CLR
    );
endinterface

// File: rtl/alp_input_conditioner.sv
// Synchronises board switches/buttons, debounces the buttons and issues
// single-cycle COMP/LOAD/CLR pulses with operands snapshotted on the same edge.
module alp_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    alp_input_conditioner_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Bit map: [0] comp, [1] load, [2] clr, [5:3] op, [9:6] data
    logic [9:0]       raw;
    logic [9:0]       sync_1;
    logic [9:0]       sync_2;
    logic [2:0]       btn_s;
    logic [2:0]       op_s;
    logic [3:0]       data_s;

    logic [2:0]       db_state;
    logic [2:0]       db_next;
    logic [CNT_W-1:0] db_cnt  [3];
    logic [CNT_W-1:0] cnt_next[3];
    logic [2:0]       rise;

    logic             ev_clr;
    logic             ev_comp;
    logic             ev_load;
    logic             ev_any;

    logic [2:0]       op_q;
    logic [3:0]       data_q;
    logic             comp_q;
    logic             load_q;
    logic             clr_q;

    assign raw    = {bus.i_sw_data, bus.i_sw_op, bus.i_btn_clr, bus.i_btn_load, bus.i_btn_comp};
    assign btn_s  = sync_2[2:0];
    assign op_s   = sync_2[5:3];
    assign data_s = sync_2[9:6];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // A level must disagree with the debounced state for DEBOUNCE_CYCLES
    // consecutive edges; any agreeing edge restarts the count.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            db_next[i]  = db_state[i];
            cnt_next[i] = '0;
            rise[i]     = 1'b0;
            if (btn_s[i] != db_state[i]) begin
                if (db_cnt[i] == CNT_TC) begin
                    db_next[i] = btn_s[i];
                    rise[i]    = btn_s[i];
                end else begin
                    cnt_next[i] = db_cnt[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            db_state <= '0;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            db_state <= db_next;
            for (int i = 0; i < 3; i++) begin
                db_cnt[i] <= cnt_next[i];
            end
        end
    end

    // Same-edge events resolve CLR > COMP > LOAD; losers are simply dropped
    // (their debounced state still advances so they cannot re-fire).
    assign ev_clr  = rise[2];
    assign ev_comp = rise[0] & ~rise[2];
    assign ev_load = rise[1] & ~rise[0] & ~rise[2];
    assign ev_any  = ev_clr | ev_comp | ev_load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q   <= '0;
            data_q <= '0;
            comp_q <= 1'b0;
            load_q <= 1'b0;
            clr_q  <= 1'b0;
        end else begin
            comp_q <= ev_comp;
            load_q <= ev_load;
            clr_q  <= ev_clr;
            if (ev_any) begin
                op_q   <= op_s;
                data_q <= data_s;
            end
        end
    end

    assign bus.o_OP   = op_q;
    assign bus.o_DATA = data_q;
    assign bus.o_COMP = comp_q;
    assign bus.o_LOAD = load_q;
    assign bus.o_CLR  = clr_q;

endmodule
